arrow_sequencer: RTL and testbench



---
 rtl/arrow_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_arrow_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : arrow_sequencer
//  Description : Round sequencer for an arrow-display game. A round clears
//                the CLR_W x CLR_H screen one pixel per cycle, launches the
//                arrow drawing unit with a new direction and colour, waits
//                for it to finish, keeps the arrow on screen for HOLD_CYCLES
//                cycles and then counts the round as complete.
//
//  Ports       : clk          - system clock, rising edge
//                reset        - synchronous active-high reset
//                go           - level request to start a round (IDLE only)
//                draw_done    - drawing unit finished (DRAW_WAIT only)
//                draw_start   - one-cycle launch pulse for the drawing unit
//                dir          - arrow direction 00 L, 01 R, 10 U, 11 D
//                colour       - arrow colour, never 000
//                clr_x/clr_y  - clear-sweep pixel coordinate
//                clr_plot     - clear-sweep write enable (black pixel)
//                busy         - high in every state except IDLE
//                round_count  - completed rounds, wraps 255 -> 0
//
//  Options     : ARROW_SEQ_LFSR_EN - when defined, direction and colour are
//                taken from a 16-bit Fibonacci LFSR instead of stepping
//                through fixed sequences.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module arrow_sequencer #(
    parameter int HOLD_CYCLES = 3125000,
    parameter int CLR_W       = 160,
    parameter int CLR_H       = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       draw_done,
    output logic       draw_start,
    output logic [1:0] dir,
    output logic [2:0] colour,
    output logic [7:0] clr_x,
    output logic [6:0] clr_y,
    output logic       clr_plot,
    output logic       busy,
    output logic [7:0] round_count
);

    // A zero hold would make HOLD last no time at all; it is stretched to one.
    localparam int c_HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int c_HOLD_W   = (c_HOLD_EFF > 1) ? $clog2(c_HOLD_EFF) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(c_HOLD_EFF - 1);
    localparam logic [7:0] c_X_LAST = 8'(CLR_W - 1);
    localparam logic [6:0] c_Y_LAST = 7'(CLR_H - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_START     = 3'd2,
        S_DRAW_WAIT = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    state_t                r_state_q,       w_state_d;
    logic [c_HOLD_W-1:0]   r_hold_cnt_q,    w_hold_cnt_d;
    logic                  r_draw_start_q,  w_draw_start_d;
    logic [1:0]            r_dir_q,         w_dir_d;
    logic [2:0]            r_colour_q,      w_colour_d;
    logic [7:0]            r_clr_x_q,       w_clr_x_d;
    logic [6:0]            r_clr_y_q,       w_clr_y_d;
    logic                  r_clr_plot_q,    w_clr_plot_d;
    logic                  r_busy_q,        w_busy_d;
    logic [7:0]            r_round_count_q, w_round_count_d;

    // Direction and colour that the next START will present.
    logic [1:0] w_next_dir;
    logic [2:0] w_next_colour;

`ifdef ARROW_SEQ_LFSR_EN
    logic [15:0] r_lfsr_q, w_lfsr_d;
    logic        w_lfsr_fb;

    // Right-shifting Fibonacci form of taps 16,14,13,11: tap n sits at bit 16-n.
    assign w_lfsr_fb     = r_lfsr_q[0] ^ r_lfsr_q[2] ^ r_lfsr_q[3] ^ r_lfsr_q[5];
    assign w_lfsr_d      = {w_lfsr_fb, r_lfsr_q[15:1]};
    assign w_next_dir    = r_lfsr_q[1:0];
    // Black would be invisible on the cleared screen, so 000 becomes white.
    assign w_next_colour = (r_lfsr_q[4:2] == 3'b000) ? 3'b111 : r_lfsr_q[4:2];
`else
    assign w_next_dir    = r_dir_q + 2'd1;
    assign w_next_colour = (r_colour_q == 3'b111) ? 3'b001 : (r_colour_q + 3'd1);
`endif

    always_comb begin
        w_state_d       = r_state_q;
        w_hold_cnt_d    = r_hold_cnt_q;
        w_draw_start_d  = 1'b0;
        w_dir_d         = r_dir_q;
        w_colour_d      = r_colour_q;
        w_clr_x_d       = r_clr_x_q;
        w_clr_y_d       = r_clr_y_q;
        w_clr_plot_d    = r_clr_plot_q;
        w_busy_d        = r_busy_q;
        w_round_count_d = r_round_count_q;

        case (r_state_q)
            S_IDLE: begin
                if (go) begin
                    w_state_d    = S_CLEAR;
                    w_clr_x_d    = 8'd0;
                    w_clr_y_d    = 7'd0;
                    w_clr_plot_d = 1'b1;
                    w_busy_d     = 1'b1;
                end
            end

            S_CLEAR: begin
                if ((r_clr_x_q == c_X_LAST) && (r_clr_y_q == c_Y_LAST)) begin
                    // Last pixel is being plotted this cycle; launch the draw.
                    w_state_d      = S_START;
                    w_clr_x_d      = 8'd0;
                    w_clr_y_d      = 7'd0;
                    w_clr_plot_d   = 1'b0;
                    w_draw_start_d = 1'b1;
                    w_dir_d        = w_next_dir;
                    w_colour_d     = w_next_colour;
                end else if (r_clr_x_q == c_X_LAST) begin
                    w_clr_x_d = 8'd0;
                    w_clr_y_d = r_clr_y_q + 7'd1;
                end else begin
                    w_clr_x_d = r_clr_x_q + 8'd1;
                end
            end

            S_START: begin
                w_state_d = S_DRAW_WAIT;
            end

            S_DRAW_WAIT: begin
                if (draw_done) begin
                    w_state_d    = S_HOLD;
                    w_hold_cnt_d = '0;
                end
            end

            S_HOLD: begin
                if (r_hold_cnt_q == c_HOLD_LAST) begin
                    w_state_d       = S_IDLE;
                    w_hold_cnt_d    = '0;
                    w_busy_d        = 1'b0;
                    w_round_count_d = r_round_count_q + 8'd1;
                end else begin
                    w_hold_cnt_d = r_hold_cnt_q + 1'b1;
                end
            end

            default: begin
                w_state_d    = S_IDLE;
                w_hold_cnt_d = '0;
                w_clr_x_d    = 8'd0;
                w_clr_y_d    = 7'd0;
                w_clr_plot_d = 1'b0;
                w_busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q       <= S_IDLE;
            r_hold_cnt_q    <= '0;
            r_draw_start_q  <= 1'b0;
            r_dir_q         <= 2'b00;
            r_colour_q      <= 3'b001;
            r_clr_x_q       <= 8'd0;
            r_clr_y_q       <= 7'd0;
            r_clr_plot_q    <= 1'b0;
            r_busy_q        <= 1'b0;
            r_round_count_q <= 8'd0;
`ifdef ARROW_SEQ_LFSR_EN
            r_lfsr_q        <= 16'hACE1;
`endif
        end else begin
            r_state_q       <= w_state_d;
            r_hold_cnt_q    <= w_hold_cnt_d;
            r_draw_start_q  <= w_draw_start_d;
            r_dir_q         <= w_dir_d;
            r_colour_q      <= w_colour_d;
            r_clr_x_q       <= w_clr_x_d;
            r_clr_y_q       <= w_clr_y_d;
            r_clr_plot_q    <= w_clr_plot_d;
            r_busy_q        <= w_busy_d;
            r_round_count_q <= w_round_count_d;
`ifdef ARROW_SEQ_LFSR_EN
            r_lfsr_q        <= w_lfsr_d;
`endif
        end
    end

    assign draw_start  = r_draw_start_q;
    assign dir         = r_dir_q;
    assign colour      = r_colour_q;
    assign clr_x       = r_clr_x_q;
    assign clr_y       = r_clr_y_q;
    assign clr_plot    = r_clr_plot_q;
    assign busy        = r_busy_q;
    assign round_count = r_round_count_q;

endmodule
`default_nettype wire

// File: tb/tb_arrow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arrow_sequencer
//  Description : Self-checking bench for arrow_sequencer. Instance 0 uses the
//                full 160x120 screen with a 4-cycle hold; instance 1 uses a
//                5x3 screen with HOLD_CYCLES=0 for fast multi-round runs.
//                A round-level model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arrow_sequencer;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_START = 2;
    localparam int P_WAIT  = 3;
    localparam int P_HOLD  = 4;

    int m_w[2]    = '{160, 5};
    int m_h[2]    = '{120, 3};
    int m_hold[2] = '{4, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v[2];
    logic       go_v[2];
    logic       done_v[2];
    logic       ds_v[2];
    logic [1:0] dir_v[2];
    logic [2:0] col_v[2];
    logic [7:0] x_v[2];
    logic [6:0] y_v[2];
    logic       plot_v[2];
    logic       busy_v[2];
    logic [7:0] rc_v[2];

    arrow_sequencer #(.HOLD_CYCLES(4), .CLR_W(160), .CLR_H(120)) u_dut_big (
        .clk(clk), .reset(rst_v[0]), .go(go_v[0]), .draw_done(done_v[0]),
        .draw_start(ds_v[0]), .dir(dir_v[0]), .colour(col_v[0]),
        .clr_x(x_v[0]), .clr_y(y_v[0]), .clr_plot(plot_v[0]),
        .busy(busy_v[0]), .round_count(rc_v[0])
    );

    arrow_sequencer #(.HOLD_CYCLES(0), .CLR_W(5), .CLR_H(3)) u_dut_small (
        .clk(clk), .reset(rst_v[1]), .go(go_v[1]), .draw_done(done_v[1]),
        .draw_start(ds_v[1]), .dir(dir_v[1]), .colour(col_v[1]),
        .clr_x(x_v[1]), .clr_y(y_v[1]), .clr_plot(plot_v[1]),
        .busy(busy_v[1]), .round_count(rc_v[1])
    );

    int vectors     = 0;
    int miscompares = 0;
    int ds_cnt[2]   = '{0, 0};

    // Round-level model: phase, clear-pixel index and the visible round data.
    bit          m_valid[2] = '{1'b0, 1'b0};
    int          m_ph[2];
    int          m_k[2];
    int          m_hcnt[2];
    int          m_dir[2];
    int          m_col[2];
    int          m_rc[2];
    logic [15:0] m_lfsr[2];

    function automatic logic [30:0] pack_dut(input int i);
        return {ds_v[i], dir_v[i], col_v[i], x_v[i], y_v[i], plot_v[i], busy_v[i], rc_v[i]};
    endfunction

    function automatic logic [30:0] pack_model(input int i);
        logic       ds, plot, busy;
        logic [7:0] x;
        logic [6:0] y;
        ds   = (m_ph[i] == P_START);
        plot = (m_ph[i] == P_CLEAR);
        busy = (m_ph[i] != P_IDLE);
        x    = plot ? 8'(m_k[i] % m_w[i]) : 8'd0;
        y    = plot ? 7'(m_k[i] / m_w[i]) : 7'd0;
        return {ds, 2'(m_dir[i]), 3'(m_col[i]), x, y, plot, busy, 8'(m_rc[i])};
    endfunction

    task automatic model_step(input int i);
        logic [15:0] cur;
        int          fb;
        int          hold_eff;
        if (rst_v[i]) begin
            m_valid[i] = 1'b1;
            m_ph[i]    = P_IDLE;
            m_k[i]     = 0;
            m_hcnt[i]  = 0;
            m_dir[i]   = 0;
            m_col[i]   = 1;
            m_rc[i]    = 0;
            m_lfsr[i]  = 16'hACE1;
            return;
        end
        if (!m_valid[i]) return;
        cur      = m_lfsr[i];
        hold_eff = (m_hold[i] < 1) ? 1 : m_hold[i];
        case (m_ph[i])
            P_IDLE: if (go_v[i]) begin m_ph[i] = P_CLEAR; m_k[i] = 0; end
            P_CLEAR: begin
                if (m_k[i] == m_w[i] * m_h[i] - 1) begin
                    m_ph[i] = P_START;
                    m_k[i]  = 0;
`ifdef ARROW_SEQ_LFSR_EN
                    m_dir[i] = int'(cur) % 4;
                    m_col[i] = (int'(cur) / 4) % 8;
                    if (m_col[i] == 0) m_col[i] = 7;
`else
                    m_dir[i] = (m_dir[i] + 1) % 4;
                    m_col[i] = (m_col[i] % 7) + 1;
`endif
                end else begin
                    m_k[i] = m_k[i] + 1;
                end
            end
            P_START: m_ph[i] = P_WAIT;
            P_WAIT:  if (done_v[i]) begin m_ph[i] = P_HOLD; m_hcnt[i] = 0; end
            P_HOLD: begin
                m_hcnt[i] = m_hcnt[i] + 1;
                if (m_hcnt[i] >= hold_eff) begin
                    m_ph[i] = P_IDLE;
                    m_rc[i] = (m_rc[i] + 1) % 256;
                end
            end
            default: m_ph[i] = P_IDLE;
        endcase
        fb        = (cur[0] ^ cur[2] ^ cur[3] ^ cur[5]) ? 1 : 0;
        m_lfsr[i] = 16'((int'(cur) >> 1) | (fb << 15));
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i]) begin
                vectors++;
                if (pack_dut(i) !== pack_model(i)) begin
                    miscompares++;
                    $display("FAIL cycle_model[%0d] t=%0t actual=%h required=%h",
                             i, $time, pack_dut(i), pack_model(i));
                end
                if (ds_v[i] === 1'b1) ds_cnt[i]++;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    initial begin
        int n, h, prev;
        logic [7:0] lx;
        logic [6:0] ly;
        logic [9:0]  dir_seq;
        logic [14:0] col_seq;
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; go_v[i] = 1'b0; done_v[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        for (int i = 0; i < 2; i++)
            chk("reset_state", longint'(pack_dut(i)),
                longint'({1'b0, 2'b00, 3'b001, 8'd0, 7'd0, 1'b0, 1'b0, 8'd0}));

        // Full-size round: one-cycle go, 19200-pixel clear, hold of 4.
        go_v[0] = 1'b1; @(negedge clk); go_v[0] = 1'b0;
        chk("busy_after_go", longint'(busy_v[0]), 1);
        n = 0; lx = '0; ly = '0;
        while (plot_v[0] && n < 20000) begin
            lx = x_v[0]; ly = y_v[0]; n++; @(negedge clk);
        end
        chk("clear_cycles", n, 19200);
        chk("last_pixel", longint'({lx, ly}), longint'({8'd159, 7'd119}));
        chk("start_after_clear", longint'(ds_v[0]), 1);
        repeat (2) @(negedge clk);
        done_v[0] = 1'b1; @(negedge clk); done_v[0] = 1'b0;
        h = 0;
        while (busy_v[0] && h < 20) begin h++; @(negedge clk); end
        chk("hold_length", h, 4);
        chk("round_count_1", longint'(rc_v[0]), 1);
        chk("start_pulses_1", ds_cnt[0], 1);

        // go/draw_done noise during CLEAR, START and HOLD.
        go_v[0] = 1'b1; @(negedge clk); go_v[0] = 1'b0;
        repeat (100) @(negedge clk);
        go_v[0] = 1'b1; done_v[0] = 1'b1; @(negedge clk);
        go_v[0] = 1'b0; done_v[0] = 1'b0;
        n = 0;
        while (!ds_v[0] && n < 20000) begin n++; @(negedge clk); end
        chk("start_seen_2", longint'(ds_v[0]), 1);
        done_v[0] = 1'b1; @(negedge clk); done_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_not_remembered", longint'(busy_v[0]), 1);
        done_v[0] = 1'b1; @(negedge clk); done_v[0] = 1'b0;
        go_v[0] = 1'b1; done_v[0] = 1'b1; @(negedge clk);
        go_v[0] = 1'b0; done_v[0] = 1'b0;
        n = 0;
        while (busy_v[0] && n < 20) begin n++; @(negedge clk); end
        chk("round_count_2", longint'(rc_v[0]), 2);
        chk("start_pulses_2", ds_cnt[0], 2);
        repeat (3) @(negedge clk);
        chk("idle_after_noise", longint'(busy_v[0]), 0);

        // Reset in the middle of the clear sweep.
        go_v[0] = 1'b1; @(negedge clk); go_v[0] = 1'b0;
        n = 0;
        while (!(x_v[0] == 8'd80 && y_v[0] == 7'd60) && n < 20000) begin n++; @(negedge clk); end
        chk("reached_80_60", longint'({x_v[0], y_v[0]}), longint'({8'd80, 7'd60}));
        rst_v[0] = 1'b1; @(negedge clk); rst_v[0] = 1'b0;
        chk("abort_state", longint'({plot_v[0], x_v[0], y_v[0], busy_v[0], rc_v[0]}), 0);
        go_v[0] = 1'b1; @(negedge clk); go_v[0] = 1'b0;
        chk("restart_origin", longint'({plot_v[0], x_v[0], y_v[0]}),
            longint'({1'b1, 8'd0, 7'd0}));
        chk("start_pulses_abort", ds_cnt[0], 2);
        rst_v[0] = 1'b1; @(negedge clk); rst_v[0] = 1'b0;

        // Small screen, go and draw_done held high: 256 back-to-back rounds.
        rst_v[1] = 1'b1; @(negedge clk); rst_v[1] = 1'b0;
        go_v[1] = 1'b1; done_v[1] = 1'b1;
        prev = 0; dir_seq = '0; col_seq = '0;
        for (int r = 0; r < 256; r++) begin
            n = 0;
            while (int'(rc_v[1]) == prev && n < 200) begin n++; @(negedge clk); end
            if (n >= 200) begin
                chk("round_timeout", n, 0);
                break;
            end
            if (r < 5) begin
                dir_seq = {dir_seq[7:0], dir_v[1]};
                col_seq = {col_seq[11:0], col_v[1]};
            end
            prev = int'(rc_v[1]);
        end
        go_v[1] = 1'b0; done_v[1] = 1'b0;
        chk("round_count_wrap", longint'(rc_v[1]), 0);
        chk("start_pulses_256", ds_cnt[1], 256);
`ifndef ARROW_SEQ_LFSR_EN
        chk("dir_sequence", longint'(dir_seq),
            longint'({2'b01, 2'b10, 2'b11, 2'b00, 2'b01}));
        chk("colour_sequence", longint'(col_seq),
            longint'({3'b010, 3'b011, 3'b100, 3'b101, 3'b110}));
`endif
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
